// File: rtl/rd_arbitrate_interface.sv
// Frame fetcher: issues DDR burst reads into the TX read FIFO, walking one frame per bank selection.
// Latency: rd_req 1 cycle after room is seen; address advances 1 cycle after the grant falls.
// Backpressure: no request while the FIFO lacks room for a full burst; bursts in flight always complete.
module rd_arbitrate_interface #(
    parameter logic [1:0]  SLAVE_NUMBER = 2'b00,
    parameter logic [20:0] MAXADDR      = 21'd245_760,
    parameter logic [9:0]  BURST_LEN    = 10'd256,
    parameter logic [10:0] FIFO_DEPTH   = 11'd1024
) (
    input  logic        ddr_clk,
    input  logic        sys_rstn,
    input  logic        rd_en,
    input  logic        wr_frame_done,
    input  logic [1:0]  wr_done_bank,
    input  logic        fifo_full_flag,
    input  logic [10:0] fifo_len,
    input  logic        arbitrate_valid,
    output logic        rd_req,
    output logic [22:0] rd_addr,
    output logic [9:0]  rd_burst_len,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        BURST = 2'd3
    } state_t;

    localparam logic [10:0] FILL_LIMIT = FIFO_DEPTH - {1'b0, BURST_LEN};

    state_t      state_q;
    logic        valid_dly_q;
    logic [1:0]  rd_bank_q;
    logic [20:0] word_addr_q;
    logic        frame_avail_q;
    logic [1:0]  latched_bank_q;
    logic        rd_req_q;
    logic        frame_start_q;
    logic        frame_done_q;
    logic [9:0]  rd_burst_len_q;

    logic [21:0] next_addr_d;
    logic        fifo_room;
    logic        grant_fall;

    // The bank always comes from the write side; the legacy default is kept only for port compatibility.
    logic unused_slave_number;
    assign unused_slave_number = ^SLAVE_NUMBER;

    assign next_addr_d = {1'b0, word_addr_q} + {12'd0, BURST_LEN};
    assign fifo_room   = (fifo_len <= FILL_LIMIT) && !fifo_full_flag;
    assign grant_fall  = !arbitrate_valid && valid_dly_q;

    always_ff @(posedge ddr_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q        <= IDLE;
            valid_dly_q    <= 1'b0;
            rd_bank_q      <= 2'b00;
            word_addr_q    <= 21'd0;
            frame_avail_q  <= 1'b0;
            latched_bank_q <= 2'b00;
            rd_req_q       <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            rd_burst_len_q <= 10'd0;
        end else begin
            valid_dly_q    <= arbitrate_valid;
            rd_burst_len_q <= BURST_LEN;
            frame_start_q  <= 1'b0;
            frame_done_q   <= 1'b0;

            // A newer frame only moves the latch; rd_bank is resampled at the next IDLE exit.
            if (wr_frame_done) begin
                latched_bank_q <= wr_done_bank;
                frame_avail_q  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (rd_en && frame_avail_q) begin
                        rd_bank_q     <= wr_frame_done ? wr_done_bank : latched_bank_q;
                        word_addr_q   <= 21'd0;
                        frame_start_q <= 1'b1;
                        state_q       <= CHECK;
                    end
                end
                CHECK: begin
                    if (!rd_en) begin
                        state_q <= IDLE;
                    end else if (fifo_room) begin
                        rd_req_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (arbitrate_valid) begin
                        rd_req_q <= 1'b0;
                        state_q  <= BURST;
                    end
                end
                BURST: begin
                    if (grant_fall) begin
                        if (next_addr_d >= {1'b0, MAXADDR}) begin
                            word_addr_q  <= 21'd0;
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            word_addr_q <= next_addr_d[20:0];
                            state_q     <= CHECK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_req       = rd_req_q;
    assign rd_addr      = {rd_bank_q, word_addr_q};
    assign rd_burst_len = rd_burst_len_q;
    assign frame_start  = frame_start_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rd_arbitrate_interface.sv
// Bench for rd_arbitrate_interface with a 1024-word frame (four bursts of 256).
module tb_rd_arbitrate_interface;

    logic        ddr_clk;
    logic        sys_rstn;
    logic        rd_en;
    logic        wr_frame_done;
    logic [1:0]  wr_done_bank;
    logic        fifo_full_flag;
    logic [10:0] fifo_len;
    logic        arbitrate_valid;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic [9:0]  rd_burst_len;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [22:0] exp_q[$];
    logic        prev_req = 1'b0;

    rd_arbitrate_interface #(
        .SLAVE_NUMBER(2'b00),
        .MAXADDR(21'd1024),
        .BURST_LEN(10'd256),
        .FIFO_DEPTH(11'd1024)
    ) dut (
        .ddr_clk(ddr_clk),
        .sys_rstn(sys_rstn),
        .rd_en(rd_en),
        .wr_frame_done(wr_frame_done),
        .wr_done_bank(wr_done_bank),
        .fifo_full_flag(fifo_full_flag),
        .fifo_len(fifo_len),
        .arbitrate_valid(arbitrate_valid),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_burst_len(rd_burst_len),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .busy(busy)
    );

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = ~ddr_clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge ddr_clk);
        #1;
    endtask

    // Scoreboard: every new request must carry the next expected burst address.
    always @(negedge ddr_clk) begin
        if (rd_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_req: got addr %0h expected no request", rd_addr);
            end else begin
                check("sb_addr", {9'd0, rd_addr}, {9'd0, exp_q.pop_front()});
            end
        end
        prev_req = rd_req;
    end

    task automatic do_burst(input int hold, input logic [22:0] addr, input logic pulse,
                            input logic [1:0] bank, input logic en_during);
        int n;
        exp_q.push_back(addr);
        n = 0;
        while (!rd_req && n < 50) begin
            step();
            n++;
        end
        check("req_seen", {31'd0, rd_req}, 32'd1);
        check("burst_len", {22'd0, rd_burst_len}, 32'd256);
        arbitrate_valid = 1'b1;
        rd_en = en_during;
        step();
        check("req_drop_on_grant", {31'd0, rd_req}, 32'd0);
        for (int i = 1; i < hold; i++) begin
            if (i == 1 && pulse) begin
                wr_frame_done = 1'b1;
                wr_done_bank  = bank;
            end
            step();
            wr_frame_done = 1'b0;
        end
        arbitrate_valid = 1'b0;
        step();
    endtask

    typedef struct {
        logic [10:0] len;
        logic        full;
        logic        exp_req;
    } vec_t;

    vec_t vecs[6];
    int   viol;

    initial begin
        vecs[0] = '{len: 11'd769,  full: 1'b0, exp_req: 1'b0};
        vecs[1] = '{len: 11'd1000, full: 1'b0, exp_req: 1'b0};
        vecs[2] = '{len: 11'd1024, full: 1'b1, exp_req: 1'b0};
        vecs[3] = '{len: 11'd768,  full: 1'b1, exp_req: 1'b0};
        vecs[4] = '{len: 11'd0,    full: 1'b1, exp_req: 1'b0};
        vecs[5] = '{len: 11'd768,  full: 1'b0, exp_req: 1'b1};

        sys_rstn = 1'b0;
        rd_en = 1'b0;
        wr_frame_done = 1'b0;
        wr_done_bank = 2'b00;
        fifo_full_flag = 1'b0;
        fifo_len = 11'd0;
        arbitrate_valid = 1'b0;
        step();
        step();
        check("rst_rd_req", {31'd0, rd_req}, 32'd0);
        check("rst_rd_addr", {9'd0, rd_addr}, 32'd0);
        check("rst_burst_len", {22'd0, rd_burst_len}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {30'd0, frame_start, frame_done}, 32'd0);
        sys_rstn = 1'b1;
        step();
        check("burst_len_after_rst", {22'd0, rd_burst_len}, 32'd256);

        // No frame available: nothing may move.
        rd_en = 1'b1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (rd_req || busy) viol++;
        end
        check("no_frame_idle", viol, 0);
        arbitrate_valid = 1'b1;
        step();
        step();
        step();
        arbitrate_valid = 1'b0;
        step();
        step();
        check("stray_grant_addr", {9'd0, rd_addr}, 32'd0);
        check("stray_grant_busy", {31'd0, busy}, 32'd0);

        // First frame from bank 01.
        wr_frame_done = 1'b1;
        wr_done_bank  = 2'b01;
        step();
        wr_frame_done = 1'b0;
        check("avail_latch_busy", {31'd0, busy}, 32'd0);
        step();
        check("frame_start_1", {31'd0, frame_start}, 32'd1);
        check("busy_check", {31'd0, busy}, 32'd1);
        do_burst(256, 23'h200000, 1'b0, 2'b00, 1'b1);
        check("addr_after_b0", {9'd0, rd_addr}, 32'h200100);
        check("no_done_b0", {31'd0, frame_done}, 32'd0);
        do_burst(4, 23'h200100, 1'b1, 2'b10, 1'b1);
        check("bank_held_b1", {9'd0, rd_addr}, 32'h200200);
        do_burst(8, 23'h200200, 1'b0, 2'b00, 1'b1);
        do_burst(3, 23'h200300, 1'b0, 2'b00, 1'b1);
        check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        check("wrap_addr", {9'd0, rd_addr}, 32'h200000);
        check("idle_after_frame", {31'd0, busy}, 32'd0);

        // Next frame picks up bank 10; the FIFO is too full to request.
        fifo_len = 11'd769;
        step();
        check("frame_done_clear", {31'd0, frame_done}, 32'd0);
        check("frame_start_2", {31'd0, frame_start}, 32'd1);
        check("new_bank_addr", {9'd0, rd_addr}, 32'h400000);
        for (int i = 0; i < 6; i++) begin
            fifo_len       = vecs[i].len;
            fifo_full_flag = vecs[i].full;
            step();
            check($sformatf("bp_vec%0d_req", i), {31'd0, rd_req}, {31'd0, vecs[i].exp_req});
            check($sformatf("bp_vec%0d_busy", i), {31'd0, busy}, 32'd1);
        end
        do_burst(5, 23'h400000, 1'b0, 2'b00, 1'b1);
        check("addr_bank10_b1", {9'd0, rd_addr}, 32'h400100);

        // Dropping rd_en mid-burst lets the burst finish, then parks in IDLE.
        do_burst(6, 23'h400100, 1'b0, 2'b00, 1'b0);
        check("abort_addr", {9'd0, rd_addr}, 32'h400200);
        check("abort_no_done", {31'd0, frame_done}, 32'd0);
        step();
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_no_done2", {31'd0, frame_done}, 32'd0);
        step();
        check("abort_addr_kept", {9'd0, rd_addr}, 32'h400200);
        check("abort_no_req", {31'd0, rd_req}, 32'd0);

        // Asynchronous reset while a request is pending.
        rd_en = 1'b1;
        exp_q.push_back(23'h400000);
        step();
        check("restart_start", {31'd0, frame_start}, 32'd1);
        step();
        check("req_pending", {31'd0, rd_req}, 32'd1);
        @(negedge ddr_clk);
        #1;
        sys_rstn = 1'b0;
        #1;
        check("async_rst_req", {31'd0, rd_req}, 32'd0);
        check("async_rst_addr", {9'd0, rd_addr}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_len", {22'd0, rd_burst_len}, 32'd0);
        step();
        sys_rstn = 1'b1;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_req || busy) viol++;
        end
        check("avail_cleared_by_rst", viol, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
